// File: rtl/twoof5_encoder_tx_if.sv
// Bus between a digit source and the 2-of-5 transmitter: digit handshake,
// parallel code word, serial output and status pulses.
// Handshake: a digit is transferred on a rising CLK edge where DIN_VALID and
// DIN_READY are both high; DIN_READY never depends on DIN_VALID, and DIGIT
// only has to be stable in the cycle of that edge.
interface twoof5_encoder_tx_if;
    logic [3:0] DIGIT;
    logic       DIN_VALID;
    logic       DIN_READY;
    logic [4:0] CODE;
    logic       SDO;
    logic       SFRAME;
    logic       WORD_DONE;
    logic       ERR;
    logic       STATE_DBG;   // 0 = IDLE, 1 = SHIFT

    modport master (
        output DIGIT, DIN_VALID,
        input  DIN_READY, CODE, SDO, SFRAME, WORD_DONE, ERR, STATE_DBG
    );

    modport slave (
        input  DIGIT, DIN_VALID,
        output DIN_READY, CODE, SDO, SFRAME, WORD_DONE, ERR, STATE_DBG
    );
endinterface

// File: rtl/twoof5_encoder_tx.sv
// Two-out-of-five transmitter: encodes BCD digits into 7-4-2-1-0 weighted
// code words and shifts them out MSB first, holding each bit BIT_CYCLES
// clocks. Non-BCD digits are rejected with a one-cycle ERR pulse.
module twoof5_encoder_tx #(
    parameter int BIT_CYCLES = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    twoof5_encoder_tx_if.slave    bus
);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;
    localparam logic [3:0] CYC_LAST = 4'(BIT_CYCLES - 1);

    logic [0:0] state_q, state_d;
    logic [4:0] shift_q, shift_d;
    logic [4:0] code_q, code_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [3:0] cyc_q, cyc_d;
    logic       sdo_q, sdo_d;
    logic       sframe_q, sframe_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       din_ready;
    logic       accept;
    logic [4:0] enc_word;

    // Weights 7-4-2-1-0; zero is the special case 11000 (7+4).
    function automatic logic [4:0] encode(input logic [3:0] d);
        case (d)
            4'd0:    encode = 5'b11000;
            4'd1:    encode = 5'b00011;
            4'd2:    encode = 5'b00101;
            4'd3:    encode = 5'b00110;
            4'd4:    encode = 5'b01001;
            4'd5:    encode = 5'b01010;
            4'd6:    encode = 5'b01100;
            4'd7:    encode = 5'b10001;
            4'd8:    encode = 5'b10010;
            4'd9:    encode = 5'b10100;
            default: encode = 5'b00000;
        endcase
    endfunction

    assign din_ready = (state_q == ST_IDLE) && !RST;
    assign accept    = bus.DIN_VALID && din_ready;
    assign enc_word  = encode(bus.DIGIT);

    // Next-state logic: load on accept, then walk bits 4..0 holding each one.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        code_d    = code_q;
        bit_idx_d = bit_idx_q;
        cyc_d     = cyc_q;
        sdo_d     = sdo_q;
        sframe_d  = sframe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                sdo_d    = 1'b0;
                sframe_d = 1'b0;
                if (accept) begin
                    if (bus.DIGIT <= 4'd9) begin
                        code_d    = enc_word;
                        shift_d   = enc_word;
                        bit_idx_d = 3'd4;
                        cyc_d     = 4'd0;
                        state_d   = ST_SHIFT;
                        sframe_d  = 1'b1;
                        sdo_d     = enc_word[4];
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d = 4'd0;
                    if (bit_idx_q == 3'd0) begin
                        // Last bit has been held long enough: close the frame.
                        state_d  = ST_IDLE;
                        sframe_d = 1'b0;
                        sdo_d    = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q - 3'd1;
                        shift_d   = {shift_q[3:0], 1'b0};
                        sdo_d     = shift_q[3];
                    end
                end else begin
                    cyc_d = cyc_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset aborts any word in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            shift_q   <= 5'd0;
            code_q    <= 5'd0;
            bit_idx_q <= 3'd0;
            cyc_q     <= 4'd0;
            sdo_q     <= 1'b0;
            sframe_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            code_q    <= code_d;
            bit_idx_q <= bit_idx_d;
            cyc_q     <= cyc_d;
            sdo_q     <= sdo_d;
            sframe_q  <= sframe_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.DIN_READY = din_ready;
    assign bus.CODE      = code_q;
    assign bus.SDO       = sdo_q;
    assign bus.SFRAME    = sframe_q;
    assign bus.WORD_DONE = done_q;
    assign bus.ERR       = err_q;
    assign bus.STATE_DBG = state_q[0];
endmodule

// File: tb/tb_twoof5_encoder_tx.sv
// Directed bench for twoof5_encoder_tx: three instances (BIT_CYCLES 2, 1, 15)
// share clock and reset; each scenario task checks its own expectations.
module tb_twoof5_encoder_tx;
    logic CLK;
    logic RST;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc_cnt  = 0;

    twoof5_encoder_tx_if bus0();
    twoof5_encoder_tx_if bus1();
    twoof5_encoder_tx_if bus2();

    twoof5_encoder_tx #(.BIT_CYCLES(2))  u_dut0 (.CLK(CLK), .RST(RST), .bus(bus0.slave));
    twoof5_encoder_tx #(.BIT_CYCLES(1))  u_dut1 (.CLK(CLK), .RST(RST), .bus(bus1.slave));
    twoof5_encoder_tx #(.BIT_CYCLES(15)) u_dut2 (.CLK(CLK), .RST(RST), .bus(bus2.slave));

    typedef struct {
        logic       sdo;
        logic       sframe;
        logic       done;
        logic       err;
        logic       ready;
        logic       state;
        logic [4:0] code;
    } obs_t;

    // Clock/reset block
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Hand-computed 7-4-2-1-0 table
    logic [4:0] exp_tab [0:9] = '{5'b11000, 5'b00011, 5'b00101, 5'b00110, 5'b01001,
                                  5'b01010, 5'b01100, 5'b10001, 5'b10010, 5'b10100};

    function automatic obs_t get_obs(input int which);
        obs_t o;
        case (which)
            1: begin
                o.sdo = bus1.SDO; o.sframe = bus1.SFRAME; o.done = bus1.WORD_DONE;
                o.err = bus1.ERR; o.ready = bus1.DIN_READY; o.state = bus1.STATE_DBG;
                o.code = bus1.CODE;
            end
            2: begin
                o.sdo = bus2.SDO; o.sframe = bus2.SFRAME; o.done = bus2.WORD_DONE;
                o.err = bus2.ERR; o.ready = bus2.DIN_READY; o.state = bus2.STATE_DBG;
                o.code = bus2.CODE;
            end
            default: begin
                o.sdo = bus0.SDO; o.sframe = bus0.SFRAME; o.done = bus0.WORD_DONE;
                o.err = bus0.ERR; o.ready = bus0.DIN_READY; o.state = bus0.STATE_DBG;
                o.code = bus0.CODE;
            end
        endcase
        return o;
    endfunction

    // Driver tasks
    task automatic drive(input int which, input logic v, input logic [3:0] d);
        case (which)
            1:       begin bus1.DIN_VALID = v; bus1.DIGIT = d; end
            2:       begin bus2.DIN_VALID = v; bus2.DIGIT = d; end
            default: begin bus0.DIN_VALID = v; bus0.DIGIT = d; end
        endcase
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    // Records SDO while SFRAME is high, starting at the current sample point.
    task automatic collect(input int which, input int budget, output logic [79:0] seq,
                           output int flen, output int rlow, output int dones, output obs_t end_o);
        obs_t o;
        seq = '0; flen = 0; rlow = 0; dones = 0;
        o = get_obs(which);
        while (o.sframe === 1'b1 && flen < budget) begin
            seq = {seq[78:0], o.sdo};
            flen++;
            if (o.ready !== 1'b1) rlow++;
            if (o.done === 1'b1) dones++;
            step();
            o = get_obs(which);
        end
        if (o.done === 1'b1) dones++;
        end_o = o;
    endtask

    function automatic logic [4:0] deser(input logic [79:0] seq, input int bc);
        logic [4:0] w;
        for (int k = 0; k < 5; k++) w[k] = seq[k*bc];
        return w;
    endfunction

    function automatic logic stable(input logic [79:0] seq, input int bc);
        logic ok = 1'b1;
        for (int k = 0; k < 5; k++)
            for (int j = 1; j < bc; j++)
                if (seq[k*bc+j] !== seq[k*bc]) ok = 1'b0;
        return ok;
    endfunction

    task automatic test_reset();
        obs_t o;
        RST = 1'b1;
        drive(0, 1'b1, 4'd5);
        drive(1, 1'b0, 4'd0);
        drive(2, 1'b0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            o = get_obs(0);
            n_checks++; if (o.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready cyc%0d: got %b expected 0", i, o.ready); end
            n_checks++; if ({o.code, o.sdo, o.sframe, o.done, o.err} !== 9'd0) begin n_fail++;
                $display("FAIL reset_outputs cyc%0d: got code=%b sdo=%b sframe=%b done=%b err=%b expected all 0", i, o.code, o.sdo, o.sframe, o.done, o.err); end
        end
        RST = 1'b0;
        drive(0, 1'b0, 4'd5);
        #1;
        o = get_obs(0);
        n_checks++; if (o.ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b expected 1", o.ready); end
        step();
        o = get_obs(0);
        n_checks++; if (o.state !== 1'b0 || o.sframe !== 1'b0) begin n_fail++; $display("FAIL reset_no_accept: got state=%b sframe=%b expected 0 0", o.state, o.sframe); end
    endtask

    task automatic test_single_word();
        obs_t o, e;
        logic [79:0] seq;
        int flen, rlow, dones;
        drive(0, 1'b1, 4'd3);
        step();
        drive(0, 1'b0, 4'd0);
        o = get_obs(0);
        n_checks++; if (o.code !== 5'b00110) begin n_fail++; $display("FAIL single_code: got %b expected 00110", o.code); end
        collect(0, 40, seq, flen, rlow, dones, e);
        n_checks++; if (flen !== 10) begin n_fail++; $display("FAIL single_frame_len: got %0d expected 10", flen); end
        n_checks++; if (seq[9:0] !== 10'b0000111100) begin n_fail++; $display("FAIL single_sdo_seq: got %b expected 0000111100", seq[9:0]); end
        n_checks++; if (dones !== 1 || e.done !== 1'b1) begin n_fail++; $display("FAIL single_word_done: got count=%0d end=%b expected 1 1", dones, e.done); end
        n_checks++; if (rlow !== 10 || e.ready !== 1'b1) begin n_fail++; $display("FAIL single_ready_low: got %0d end=%b expected 10 1", rlow, e.ready); end
        n_checks++; if (e.sdo !== 1'b0) begin n_fail++; $display("FAIL single_end_sdo: got %b expected 0", e.sdo); end
    endtask

    task automatic test_all_digits();
        obs_t o, e;
        logic [79:0] seq;
        int flen, rlow, dones, t_prev, t_now;
        t_prev = 0;
        drive(0, 1'b1, 4'd0);
        step();
        for (int d = 0; d < 10; d++) begin
            t_now = cyc_cnt;
            o = get_obs(0);
            if (d < 9) drive(0, 1'b1, 4'(d + 1)); else drive(0, 1'b0, 4'd0);
            n_checks++; if (o.code !== exp_tab[d]) begin n_fail++; $display("FAIL sweep_code d=%0d: got %b expected %b", d, o.code, exp_tab[d]); end
            n_checks++; if ($countones(o.code) !== 2) begin n_fail++; $display("FAIL sweep_checker_det d=%0d: got %0d ones expected 2", d, $countones(o.code)); end
            if (d > 0) begin
                n_checks++; if (t_now - t_prev !== 11) begin n_fail++; $display("FAIL sweep_period d=%0d: got %0d expected 11", d, t_now - t_prev); end
            end
            t_prev = t_now;
            collect(0, 40, seq, flen, rlow, dones, e);
            n_checks++; if (deser(seq, 2) !== exp_tab[d] || stable(seq, 2) !== 1'b1 || flen !== 10) begin n_fail++;
                $display("FAIL sweep_serial d=%0d: got %b (len %0d) expected %b (len 10)", d, deser(seq, 2), flen, exp_tab[d]); end
            if (d < 9) step();
        end
    endtask

    task automatic test_invalid_digits();
        obs_t o, e;
        logic [79:0] seq;
        int flen, rlow, dones;
        drive(0, 1'b1, 4'd10);
        step();
        o = get_obs(0);
        drive(0, 1'b1, 4'd15);
        n_checks++; if (o.err !== 1'b1 || o.done !== 1'b0) begin n_fail++; $display("FAIL invalid10_err: got err=%b done=%b expected 1 0", o.err, o.done); end
        n_checks++; if (o.code !== 5'b10100 || o.sframe !== 1'b0 || o.sdo !== 1'b0) begin n_fail++;
            $display("FAIL invalid10_hold: got code=%b sframe=%b sdo=%b expected 10100 0 0", o.code, o.sframe, o.sdo); end
        step();
        o = get_obs(0);
        drive(0, 1'b1, 4'd4);
        n_checks++; if (o.err !== 1'b1 || o.code !== 5'b10100 || o.ready !== 1'b1) begin n_fail++;
            $display("FAIL invalid15_err: got err=%b code=%b ready=%b expected 1 10100 1", o.err, o.code, o.ready); end
        step();
        o = get_obs(0);
        drive(0, 1'b0, 4'd0);
        n_checks++; if (o.err !== 1'b0 || o.code !== 5'b01001 || o.sframe !== 1'b1) begin n_fail++;
            $display("FAIL invalid_then4: got err=%b code=%b sframe=%b expected 0 01001 1", o.err, o.code, o.sframe); end
        collect(0, 40, seq, flen, rlow, dones, e);
        n_checks++; if (dones !== 1 || deser(seq, 2) !== 5'b01001) begin n_fail++;
            $display("FAIL invalid_word4: got done=%0d word=%b expected 1 01001", dones, deser(seq, 2)); end
    endtask

    task automatic test_handshake_abort();
        obs_t o, e;
        logic [79:0] seq;
        int flen, rlow, dones, bad;
        step();
        drive(0, 1'b1, 4'd7);
        step();
        drive(0, 1'b1, 4'd2);
        collect(0, 40, seq, flen, rlow, dones, e);
        drive(0, 1'b0, 4'd0);
        n_checks++; if (deser(seq, 2) !== 5'b10001 || e.code !== 5'b10001) begin n_fail++;
            $display("FAIL shift_ignores_valid: got word=%b code=%b expected 10001 10001", deser(seq, 2), e.code); end
        step();
        drive(0, 1'b1, 4'd9);
        step();
        drive(0, 1'b0, 4'd0);
        for (int i = 0; i < 4; i++) step();
        o = get_obs(0);
        n_checks++; if (o.sdo !== 1'b1 || o.sframe !== 1'b1) begin n_fail++; $display("FAIL abort_bit2: got sdo=%b sframe=%b expected 1 1", o.sdo, o.sframe); end
        RST = 1'b1;
        step();
        o = get_obs(0);
        RST = 1'b0;
        n_checks++; if ({o.sdo, o.sframe, o.done, o.code} !== 8'd0) begin n_fail++;
            $display("FAIL abort_outputs: got sdo=%b sframe=%b done=%b code=%b expected all 0", o.sdo, o.sframe, o.done, o.code); end
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            o = get_obs(0);
            if (o.done !== 1'b0 || o.sframe !== 1'b0) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d active cycles expected 0", bad); end
    endtask

    task automatic test_bit_cycles_1();
        obs_t o, e;
        logic [79:0] seq;
        int flen, rlow, dones, t0;
        drive(1, 1'b1, 4'd0);
        step();
        t0 = cyc_cnt;
        o = get_obs(1);
        n_checks++; if (o.code !== 5'b11000) begin n_fail++; $display("FAIL bc1_code: got %b expected 11000", o.code); end
        collect(1, 20, seq, flen, rlow, dones, e);
        n_checks++; if (flen !== 5 || seq[4:0] !== 5'b11000) begin n_fail++; $display("FAIL bc1_sdo_seq: got %b len %0d expected 11000 len 5", seq[4:0], flen); end
        n_checks++; if (e.done !== 1'b1) begin n_fail++; $display("FAIL bc1_done: got %b expected 1", e.done); end
        step();
        o = get_obs(1);
        drive(1, 1'b0, 4'd0);
        n_checks++; if (o.sframe !== 1'b1 || cyc_cnt - t0 !== 6) begin n_fail++;
            $display("FAIL bc1_period: got sframe=%b period=%0d expected 1 6", o.sframe, cyc_cnt - t0); end
        collect(1, 20, seq, flen, rlow, dones, e);
    endtask

    task automatic test_bit_cycles_15();
        obs_t e;
        logic [79:0] seq;
        int flen, rlow, dones;
        drive(2, 1'b1, 4'd7);
        step();
        drive(2, 1'b0, 4'd0);
        collect(2, 80, seq, flen, rlow, dones, e);
        n_checks++; if (flen !== 75) begin n_fail++; $display("FAIL bc15_frame_len: got %0d expected 75", flen); end
        n_checks++; if (deser(seq, 15) !== 5'b10001 || stable(seq, 15) !== 1'b1) begin n_fail++;
            $display("FAIL bc15_bits: got %b stable=%b expected 10001 1", deser(seq, 15), stable(seq, 15)); end
        n_checks++; if (dones !== 1) begin n_fail++; $display("FAIL bc15_done: got %0d expected 1", dones); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_all_digits();
        test_invalid_digits();
        test_handshake_abort();
        test_bit_cycles_1();
        test_bit_cycles_15();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
